// File: rtl/riscv_test_sequencer_pkg.sv
// Shared definitions for the RV32I test sequencer.
// Contents:
//   XLEN        core register width
//   DATA_W_DEF  default width of result/expected words
//   seq_state_t sequencer FSM state encoding
//   max_int     helper used to size the shared cycle counter
package riscv_test_pkg;

    localparam int XLEN       = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RST_HOLD = 3'd2,
        ST_RUN      = 3'd3,
        ST_CHECK    = 3'd4,
        ST_NEXT     = 3'd5,
        ST_DONE     = 3'd6
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/riscv_test_sequencer_if.sv
// Bus between the test sequencer and the core / memory loader.
// Signals:
//   test_id     index of the test in progress            (sequencer -> env)
//   load_req    memory load request, level until ack     (sequencer -> env)
//   load_done   memory load complete                     (env -> sequencer)
//   core_rst_n  active-low reset to the core             (sequencer -> env)
//   core_halt   core reached end-of-test                 (env -> sequencer)
//   result      result word read back from the core      (env -> sequencer)
//   expected    expected result for test_id              (env -> sequencer)
// Modports: master = sequencer side, slave = core/loader side.
interface riscv_test_sequencer_if #(
    parameter int NUM_TESTS = 2,
    parameter int DATA_W    = 32
);
    localparam int ID_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;

    logic [ID_W-1:0]   test_id;
    logic              load_req;
    logic              load_done;
    logic              core_rst_n;
    logic              core_halt;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] expected;

    modport master (
        output test_id, load_req, core_rst_n,
        input  load_done, core_halt, result, expected
    );

    modport slave (
        input  test_id, load_req, core_rst_n,
        output load_done, core_halt, result, expected
    );
endinterface

// File: rtl/riscv_test_sequencer_cycle_counter.sv
// Free-running up counter with synchronous clear and terminal-count flag.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clear_i     force count to zero on the next edge (wins over enable_i)
//   enable_i    increment on the next edge
//   limit_i     terminal value compared against the current count
//   count_o     current count
//   tc_o        count_o == limit_i
module cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == limit_i);
endmodule

// File: rtl/riscv_test_sequencer.sv
// Runs NUM_TESTS test programs back to back on the RV32I core: per test it
// requests a memory load, holds the core in reset RST_CYCLES cycles, runs it
// until halt or TIMEOUT_CYCLES, compares the result word and logs pass/timeout.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start_i      pulse, start the sequence at test 0 (only from IDLE/DONE)
//   abort_i      pulse, abandon the running test and go to DONE
//   bus          master side of the core/loader bus
//   busy_o       sequence running
//   done_o       sequence finished, held until the next start
//   pass_vec_o   bit i set when test i passed
//   tmo_vec_o    bit i set when test i timed out
//   all_pass_o   done_o and every test passed
// All outputs are flop outputs, so core_rst_n never glitches.
module riscv_test_sequencer
    import riscv_test_pkg::*;
#(
    parameter int NUM_TESTS      = 2,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int RST_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    riscv_test_sequencer_if.master bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NUM_TESTS-1:0]   pass_vec_o,
    output logic [NUM_TESTS-1:0]   tmo_vec_o,
    output logic                   all_pass_o
);
    localparam int ID_W  = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
    localparam int CNT_W = $clog2(max_int(RST_CYCLES, TIMEOUT_CYCLES)) + 1;

    seq_state_t           state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 load_req_q, load_req_d;
    logic                 core_rst_n_q, core_rst_n_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NUM_TESTS-1:0] pass_q, pass_d;
    logic [NUM_TESTS-1:0] tmo_q, tmo_d;
    logic                 all_pass_q, all_pass_d;

    logic [DATA_W-1:0]    result_w;
    logic [DATA_W-1:0]    expected_w;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic [CNT_W-1:0]     cnt_limit;
    logic [CNT_W-1:0]     cnt_val;
    logic                 cnt_tc;

    assign result_w   = bus.result;
    assign expected_w = bus.expected;

    // RST_HOLD and RUN are mutually exclusive, so one counter serves both;
    // it restarts from zero on every state change.
    assign cnt_clr   = (state_d != state_q);
    assign cnt_en    = (state_q == ST_RST_HOLD) || (state_q == ST_RUN);
    assign cnt_limit = (state_q == ST_RST_HOLD) ? CNT_W'(RST_CYCLES - 1)
                                                : CNT_W'(TIMEOUT_CYCLES - 1);

    cycle_counter #(.WIDTH(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (cnt_clr),
        .enable_i (cnt_en),
        .limit_i  (cnt_limit),
        .count_o  (cnt_val),
        .tc_o     (cnt_tc)
    );

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        load_req_d   = load_req_q;
        core_rst_n_d = core_rst_n_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        tmo_d        = tmo_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i && !abort_i) begin
                    state_d    = ST_LOAD;
                    id_d       = '0;
                    pass_d     = '0;
                    tmo_d      = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    load_req_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (load_done_or_abort()) begin
                    state_d    = abort_i ? ST_DONE : ST_RST_HOLD;
                    load_req_d = 1'b0;
                end
            end
            ST_RST_HOLD: begin
                if (!abort_i && cnt_tc) begin
                    state_d      = ST_RUN;
                    core_rst_n_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Halt is tested first so it beats a same-cycle timeout.
                if (!abort_i && bus.core_halt) begin
                    state_d = ST_CHECK;
                end else if (!abort_i && cnt_tc) begin
                    state_d      = ST_NEXT;
                    tmo_d[id_q]  = 1'b1;
                    core_rst_n_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (!abort_i) begin
                    state_d      = ST_NEXT;
                    pass_d[id_q] = (result_w == expected_w);
                    core_rst_n_d = 1'b0;
                end
            end
            ST_NEXT: begin
                if (id_q == ID_W'(NUM_TESTS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_LOAD;
                    id_d       = id_q + ID_W'(1);
                    load_req_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort from any active test state lands in DONE with the core held in reset.
        if (abort_i && (state_q == ST_LOAD || state_q == ST_RST_HOLD ||
                        state_q == ST_RUN  || state_q == ST_CHECK)) begin
            state_d = ST_DONE;
        end

        if (state_d == ST_DONE) begin
            busy_d       = 1'b0;
            done_d       = 1'b1;
            load_req_d   = 1'b0;
            core_rst_n_d = 1'b0;
        end

        all_pass_d = (state_d == ST_DONE) && (&pass_d);
    end

    function automatic logic load_done_or_abort();
        return bus.load_done || abort_i;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            load_req_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= '0;
            tmo_q        <= '0;
            all_pass_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            load_req_q   <= load_req_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            tmo_q        <= tmo_d;
            all_pass_q   <= all_pass_d;
        end
    end

    assign bus.test_id    = id_q;
    assign bus.load_req   = load_req_q;
    assign bus.core_rst_n = core_rst_n_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_vec_o     = pass_q;
    assign tmo_vec_o      = tmo_q;
    assign all_pass_o     = all_pass_q;

    // The counter value itself is only consumed through its terminal flag.
    logic unused_cnt;
    assign unused_cnt = ^cnt_val;
endmodule

// File: tb/tb_riscv_test_sequencer.sv
module tb_riscv_test_sequencer;
    localparam int NT    = 2;
    localparam int RSTC  = 10;
    localparam int TMO   = 16;
    localparam int NEVER = 255;
    localparam int BUDGET = 2000;

    logic clk;
    logic rst_n;
    logic start;
    logic abort;
    logic busy;
    logic done;
    logic [NT-1:0] pass_vec;
    logic [NT-1:0] tmo_vec;
    logic all_pass;

    riscv_test_sequencer_if #(.NUM_TESTS(NT), .DATA_W(32)) sbus ();

    riscv_test_sequencer #(
        .NUM_TESTS(NT), .DATA_W(32), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .abort_i    (abort),
        .bus        (sbus),
        .busy_o     (busy),
        .done_o     (done),
        .pass_vec_o (pass_vec),
        .tmo_vec_o  (tmo_vec),
        .all_pass_o (all_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0][7:0]  lat;
        logic [1:0][7:0]  halt;
        logic [1:0][31:0] res;
        logic [1:0][31:0] exp;
        logic [1:0]       e_pass;
        logic [1:0]       e_tmo;
        logic             e_all;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Scenario currently presented by the core/loader model.
    logic [1:0][7:0]  cur_lat;
    logic [1:0][7:0]  cur_halt;
    logic [1:0][31:0] cur_res;
    logic [1:0][31:0] cur_exp;
    int rst_meas_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    function automatic vec_t mk(input int l0, input int l1, input int h0, input int h1,
                                input logic [31:0] r0, input logic [31:0] e0,
                                input logic [31:0] r1, input logic [31:0] e1,
                                input logic [1:0] p, input logic [1:0] t, input logic a);
        vec_t v;
        v.lat    = {8'(l1), 8'(l0)};
        v.halt   = {8'(h1), 8'(h0)};
        v.res    = {r1, r0};
        v.exp    = {e1, e0};
        v.e_pass = p;
        v.e_tmo  = t;
        v.e_all  = a;
        return v;
    endfunction

    // Expected outcome from the test rules: a test halting within the timeout
    // window passes iff result matches; otherwise it times out. Cycle cost is
    // load + reset hold + run + CHECK + NEXT (no CHECK on timeout).
    task automatic model(input vec_t v, output logic [1:0] p, output logic [1:0] t, output int cyc);
        p = '0;
        t = '0;
        cyc = 0;
        for (int i = 0; i < NT; i++) begin
            if (int'(v.halt[i]) <= TMO - 1) begin
                p[i] = (v.res[i] == v.exp[i]);
                cyc += int'(v.lat[i]) + RSTC + int'(v.halt[i]) + 1 + 2;
            end else begin
                t[i] = 1'b1;
                cyc += int'(v.lat[i]) + RSTC + TMO + 1;
            end
        end
    endtask

    // Core and memory-loader model.
    initial begin
        int ld_cnt;
        int run_cnt;
        int idx;
        int meas_cnt;
        bit meas_on;
        logic prev_lr;
        ld_cnt = 0; run_cnt = 0; meas_cnt = 0; meas_on = 0; prev_lr = 0;
        sbus.load_done = 1'b0;
        sbus.core_halt = 1'b0;
        sbus.result    = '0;
        sbus.expected  = '0;
        forever begin
            @(negedge clk);
            idx = int'(sbus.test_id);
            if (sbus.load_req) begin
                ld_cnt++;
                sbus.load_done = (ld_cnt >= int'(cur_lat[idx]));
            end else begin
                ld_cnt = 0;
                sbus.load_done = 1'b0;
            end
            if (sbus.core_rst_n) begin
                sbus.core_halt = (run_cnt >= int'(cur_halt[idx]));
                run_cnt++;
            end else begin
                run_cnt = 0;
                sbus.core_halt = 1'b0;
            end
            sbus.result   = cur_res[idx];
            sbus.expected = cur_exp[idx];
            // Measure how long core reset stays low once a load is acknowledged.
            if (!busy) begin
                meas_on = 0;
            end else begin
                if (prev_lr && !sbus.load_req) begin
                    meas_on = 1;
                    meas_cnt = 0;
                end
                if (meas_on) begin
                    if (!sbus.core_rst_n) meas_cnt++;
                    else begin
                        rst_meas_q.push_back(meas_cnt);
                        meas_on = 0;
                    end
                end
            end
            prev_lr = sbus.load_req;
        end
    end

    task automatic set_scn(input vec_t v);
        cur_lat  = v.lat;
        cur_halt = v.halt;
        cur_res  = v.res;
        cur_exp  = v.exp;
    endtask

    task automatic run_seq(input string nm, input bit poke_start, output int cycles);
        rst_meas_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({nm, " start id/busy"}, {62'd0, sbus.test_id, busy}, 64'h1);
        cycles = 0;
        while (1) begin
            @(posedge clk);
            cycles++;
            #1;
            start = (poke_start && cycles == 5);
            if (done) break;
            if (cycles > BUDGET) begin
                chk({nm, " done timeout"}, 64'd0, 64'd1);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_rst_meas(input string nm);
        chk({nm, " rst-hold count"}, 64'(rst_meas_q.size()), 64'(NT));
        foreach (rst_meas_q[k]) chk({nm, " rst low cycles"}, 64'(rst_meas_q[k]), 64'(RSTC));
    endtask

    task automatic wait_run(input int want_id);
        int n;
        n = 0;
        while (!(sbus.core_rst_n && int'(sbus.test_id) == want_id) && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= BUDGET) chk("wait for RUN", 64'd0, 64'd1);
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        int cyc;
        int m_cyc;
        logic [1:0] m_p, m_t;
        string nm;

        vecs[0] = mk(1, 1, 10, 10, 32'h11, 32'h11, 32'h22, 32'h22, 2'b11, 2'b00, 1'b1);
        vecs[1] = mk(2, 1, 10, 10, 32'h7,  32'h7,  32'h5,  32'h6,  2'b01, 2'b00, 1'b0);
        vecs[2] = mk(1, 2, NEVER, 4, 32'h1, 32'h1, 32'h9, 32'h9,   2'b10, 2'b01, 1'b0);
        vecs[3] = mk(1, 1, 15, 15, 32'hA,  32'hA,  32'hB,  32'hB,  2'b11, 2'b00, 1'b1);
        vecs[4] = mk(3, 3, 0, 0,   32'hC,  32'hC,  32'hD,  32'hD,  2'b11, 2'b00, 1'b1);
        vecs[5] = mk(1, 1, NEVER, 16, 32'h3, 32'h3, 32'h4, 32'h4,  2'b00, 2'b11, 1'b0);

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_scn(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {56'd0, sbus.test_id, sbus.load_req, sbus.core_rst_n, busy, done,
                              pass_vec, tmo_vec, all_pass}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle after reset", {60'd0, sbus.core_rst_n, sbus.load_req, busy, done}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            nm = $sformatf("vec%0d", i);
            set_scn(vecs[i]);
            run_seq(nm, i == 2, cyc);
            model(vecs[i], m_p, m_t, m_cyc);
            chk({nm, " pass_vec"}, 64'(pass_vec), 64'(vecs[i].e_pass));
            chk({nm, " tmo_vec"},  64'(tmo_vec),  64'(vecs[i].e_tmo));
            chk({nm, " all_pass"}, 64'(all_pass), 64'(vecs[i].e_all));
            chk({nm, " busy/core_rst_n"}, {62'd0, busy, sbus.core_rst_n}, 64'd0);
            chk({nm, " cycles"}, 64'(cyc), 64'(m_cyc));
            check_rst_meas(nm);
        end

        // Abort wins over start while in DONE.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort beats start", {62'd0, done, busy}, 64'h2);
        start = 1'b0;
        abort = 1'b0;

        // Abort during RUN of test 0.
        set_scn(mk(1, 1, NEVER, 3, 32'h1, 32'h1, 32'h2, 32'h2, 2'b00, 2'b00, 1'b0));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_run(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort done/busy/core_rst_n", {61'd0, done, busy, sbus.core_rst_n}, 64'h4);
        chk("abort vectors", {59'd0, pass_vec, tmo_vec, all_pass}, 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort holds DONE", {62'd0, done, sbus.load_req}, 64'h2);

        set_scn(vecs[1]);
        run_seq("restart", 1'b0, cyc);
        model(vecs[1], m_p, m_t, m_cyc);
        chk("restart pass_vec", 64'(pass_vec), 64'(m_p));
        chk("restart cycles", 64'(cyc), 64'(m_cyc));

        for (int r = 0; r < 6; r++) begin
            rv = mk(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                    32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
            rv.res[0] = $urandom;
            rv.res[1] = $urandom;
            rv.exp[0] = $urandom_range(0, 1) ? rv.res[0] : (rv.res[0] ^ 32'h1);
            rv.exp[1] = $urandom_range(0, 1) ? rv.res[1] : (rv.res[1] ^ 32'h80);
            nm = $sformatf("rand%0d", r);
            set_scn(rv);
            run_seq(nm, 1'b0, cyc);
            model(rv, m_p, m_t, m_cyc);
            chk({nm, " pass_vec"}, 64'(pass_vec), 64'(m_p));
            chk({nm, " tmo_vec"},  64'(tmo_vec),  64'(m_t));
            chk({nm, " all_pass"}, 64'(all_pass), 64'(&m_p));
            chk({nm, " cycles"},   64'(cyc),      64'(m_cyc));
        end

        // Asynchronous reset in the middle of test 1's RUN.
        set_scn(mk(1, 1, 2, NEVER, 32'h1, 32'h1, 32'h2, 32'h2, 2'b00, 2'b00, 1'b0));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_run(1);
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset state", {60'd0, pass_vec, busy, sbus.core_rst_n}, 64'h7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", {56'd0, sbus.test_id, sbus.load_req, sbus.core_rst_n, busy, done,
                                    pass_vec, tmo_vec, all_pass}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_scn(vecs[0]);
        run_seq("post-reset", 1'b0, cyc);
        chk("post-reset pass_vec", 64'(pass_vec), 64'(vecs[0].e_pass));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
